// File: rtl/cmem_pkg.sv
// cmem_pkg: shared constants, csel encodings and FSM state type for the result-memory arbiter
package cmem_pkg;
  localparam int CMEM_AW = 12;
  localparam int CMEM_DW = 20;
  localparam int CMEM_SW = 3;
  localparam logic [CMEM_SW-1:0] CSEL_NONE  = 3'd0;
  localparam logic [CMEM_SW-1:0] CSEL_L0_K0 = 3'd1;
  localparam logic [CMEM_SW-1:0] CSEL_L0_K1 = 3'd2;
  localparam logic [CMEM_SW-1:0] CSEL_L1_K0 = 3'd3;
  localparam logic [CMEM_SW-1:0] CSEL_L1_K1 = 3'd4;
  localparam logic [CMEM_SW-1:0] CSEL_L2    = 3'd5;
  typedef enum logic {ARB, LOCKED} state_t;
endpackage

// File: rtl/cmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid&mask candidate after ptr wins (one-hot grant)
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant
);
  logic [N-1:0] cand;
  assign cand = valid & mask;
  // farthest offset first so the nearest candidate after ptr overwrites last
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if (cand[i] && ((int'(ptr) + k) % N) == i) grant = N'(1) << i;
  end
endmodule

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: round-robin arbiter with burst lock sharing the result-memory port among NREQ requesters.
// Optional: define CMEM_ARB_URGENT_EN to make requester 0 win every ARB cycle without moving the pointer.
module cmem_arbiter
  import cmem_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = CMEM_AW,
  parameter int DW        = CMEM_DW,
  parameter int SW        = CMEM_SW,
  parameter int RD_LAT    = 1,
  parameter int BURST_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*SW-1:0] req_sel,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic             cwr,
  output logic             crd,
  output logic [AW-1:0]    caddr,
  output logic [DW-1:0]    cdata_wr,
  output logic [SW-1:0]    csel,
  input  logic [DW-1:0]    cdata_rd,
  output logic             busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  state_t                      state;
  logic [PW-1:0]               ptr, owner, gidx;
  logic [CW-1:0]               cnt;
  logic [RD_LAT:0][NREQ-1:0]   pipe;
  logic [NREQ-1:0]             pick, arb_grant, lk_grant, grant, own_oh;
  logic                        hs, others, owner_v, owner_lock, g_we, g_lock;
  logic [AW-1:0]               g_addr;
  logic [DW-1:0]               g_wdata;
  logic [SW-1:0]               g_sel;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid(req_valid),
    .ptr  (ptr),
    .mask ({NREQ{1'b1}}),
    .grant(pick)
  );

  assign own_oh     = NREQ'(1) << owner;
  assign others     = |(req_valid & ~own_oh);
  assign owner_v    = |(req_valid & own_oh);
  assign owner_lock = |(req_lock & own_oh);
`ifdef CMEM_ARB_URGENT_EN
  assign arb_grant = req_valid[0] ? NREQ'(1) : pick;
`else
  assign arb_grant = pick;
`endif
  // a locked owner keeps going past BURST_MAX only while nobody else waits
  assign lk_grant  = (owner_v && (!owner_lock || cnt < CW'(BURST_MAX) || !others)) ? own_oh : '0;
  assign grant     = (state == ARB) ? arb_grant : lk_grant;
  assign req_ready = grant;
  assign hs        = |grant;
  assign busy      = cwr | crd | (|pipe);

  always_comb begin
    gidx    = '0;
    g_we    = 1'b0;
    g_lock  = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_sel   = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        gidx    = PW'(i);
        g_we    = req_we[i];
        g_lock  = req_lock[i];
        g_addr  = req_addr[i*AW +: AW];
        g_wdata = req_wdata[i*DW +: DW];
        g_sel   = req_sel[i*SW +: SW];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      ptr       <= PW'(NREQ - 1);
      owner     <= '0;
      cnt       <= '0;
      pipe      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      cwr       <= 1'b0;
      crd       <= 1'b0;
      caddr     <= '0;
      cdata_wr  <= '0;
      csel      <= '0;
    end else begin
      cwr <= hs & g_we;
      crd <= hs & ~g_we;
      if (hs) begin
        caddr    <= g_addr;
        cdata_wr <= g_wdata;
        csel     <= g_sel;
      end
      pipe      <= {pipe[RD_LAT-1:0], (hs && !g_we) ? grant : {NREQ{1'b0}}};
      rsp_valid <= pipe[RD_LAT];
      if (|pipe[RD_LAT]) rsp_data <= cdata_rd;
      if (state == ARB) begin
        if (hs) begin
`ifdef CMEM_ARB_URGENT_EN
          if (!grant[0]) ptr <= gidx;
`else
          ptr <= gidx;
`endif
          if (g_lock) begin
            state <= LOCKED;
            owner <= gidx;
            cnt   <= CW'(1);
          end
        end
      end else if (!hs || !g_lock) state <= ARB;
      else cnt <= (cnt == CW'(BURST_MAX)) ? cnt : cnt + CW'(1);
    end
  end
endmodule
